// File: rtl/uart_rx_pkt_ctl.sv
// rtl/uart_rx_pkt_ctl.sv - UART byte-to-packet sequencer with header/length/checksum framing
// Collects [HDR0][HDR1][LEN][payload][SUM] frames into a 16-entry buffer and holds each verified packet for the host.
module uart_rx_pkt_ctl #(
    parameter logic [7:0] HDR0    = 8'hAA,
    parameter logic [7:0] HDR1    = 8'h55,
    parameter int         MAXLEN  = 16,
    parameter int         TIMEOUT = 50000
) (
    input  logic       CLK,
    input  logic       RSTn,
    input  logic       Enable,
    input  logic       Rx_done,
    input  logic [7:0] Rx_byte,
    output logic       Rx_en,
    output logic       Pkt_valid,
    output logic [4:0] Pkt_len,
    input  logic [3:0] Pkt_addr,
    output logic [7:0] Pkt_data,
    input  logic       Pkt_rd,
    output logic       Err_sig,
    output logic [7:0] Err_cnt
);

    typedef enum logic [2:0] {IDLE, H1, LEN, DATA, SUM, HOLD} state_t;

    state_t      state;
    logic [4:0]  len;
    logic [3:0]  cnt;
    logic [7:0]  sum;
    logic [15:0] tmo_cnt;
    logic [7:0]  pkt_mem [16];

    logic active;
    logic len_ok;
    logic tmo_hit;
    logic frame_err;
    logic err_det;

    // Reset also gates the receiver so it stays quiet while the controller is held in reset.
    assign Rx_en = RSTn && Enable && (state != HOLD);

    always_comb begin
        active    = (state == H1) || (state == LEN) || (state == DATA) || (state == SUM);
        len_ok    = (Rx_byte != 8'd0) && (Rx_byte <= 8'(MAXLEN));
        tmo_hit   = active && !Rx_done && (tmo_cnt == 16'(TIMEOUT - 1));
        frame_err = 1'b0;
        if (Rx_done) begin
            case (state)
                H1:      frame_err = (Rx_byte != HDR1) && (Rx_byte != HDR0);
                LEN:     frame_err = !len_ok;
                SUM:     frame_err = (Rx_byte != sum);
                default: frame_err = 1'b0;
            endcase
        end
        err_det = Enable && (tmo_hit || frame_err);
    end

    // Payload storage has no reset; contents are only meaningful while Pkt_valid is high.
    always_ff @(posedge CLK) begin
        if (Enable && Rx_done && (state == DATA))
            pkt_mem[cnt] <= Rx_byte;
    end

    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            state     <= IDLE;
            len       <= 5'd0;
            cnt       <= 4'd0;
            sum       <= 8'd0;
            tmo_cnt   <= 16'd0;
            Pkt_valid <= 1'b0;
            Pkt_len   <= 5'd0;
            Pkt_data  <= 8'd0;
            Err_sig   <= 1'b0;
            Err_cnt   <= 8'd0;
        end else begin
            Err_sig  <= err_det;
            Pkt_data <= pkt_mem[Pkt_addr];
            if (err_det && (Err_cnt != 8'hFF))
                Err_cnt <= Err_cnt + 8'd1;

            if (!Enable) begin
                state     <= IDLE;
                Pkt_valid <= 1'b0;
                tmo_cnt   <= 16'd0;
            end else if (tmo_hit) begin
                state   <= IDLE;
                tmo_cnt <= 16'd0;
            end else begin
                if (active)
                    tmo_cnt <= Rx_done ? 16'd0 : tmo_cnt + 16'd1;
                else
                    tmo_cnt <= 16'd0;

                case (state)
                    IDLE: begin
                        if (Rx_done && (Rx_byte == HDR0))
                            state <= H1;
                    end
                    H1: begin
                        if (Rx_done) begin
                            if (Rx_byte == HDR1)
                                state <= LEN;
                            else if (Rx_byte != HDR0)
                                state <= IDLE;
                        end
                    end
                    LEN: begin
                        if (Rx_done) begin
                            if (len_ok) begin
                                state <= DATA;
                                len   <= Rx_byte[4:0];
                                cnt   <= 4'd0;
                                sum   <= Rx_byte;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    DATA: begin
                        if (Rx_done) begin
                            sum <= sum + Rx_byte;
                            cnt <= cnt + 4'd1;
                            if ({1'b0, cnt} == len - 5'd1)
                                state <= SUM;
                        end
                    end
                    SUM: begin
                        if (Rx_done) begin
                            if (Rx_byte == sum) begin
                                state     <= HOLD;
                                Pkt_valid <= 1'b1;
                                Pkt_len   <= len;
                            end else begin
                                state <= IDLE;
                            end
                        end
                    end
                    HOLD: begin
                        if (Pkt_rd) begin
                            state     <= IDLE;
                            Pkt_valid <= 1'b0;
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_rx_pkt_ctl.sv
// tb/tb_uart_rx_pkt_ctl.sv - directed bench for uart_rx_pkt_ctl
`timescale 1ns/1ps
module tb_uart_rx_pkt_ctl;

    logic       CLK = 1'b0;
    logic       RSTn = 1'b0;
    logic       Enable = 1'b0;
    logic       Rx_done = 1'b0;
    logic [7:0] Rx_byte = 8'd0;
    logic       Rx_en;
    logic       Pkt_valid;
    logic [4:0] Pkt_len;
    logic [3:0] Pkt_addr = 4'd0;
    logic [7:0] Pkt_data;
    logic       Pkt_rd = 1'b0;
    logic       Err_sig;
    logic [7:0] Err_cnt;

    int vectors = 0;
    int miscompares = 0;

    uart_rx_pkt_ctl dut (
        .CLK(CLK), .RSTn(RSTn), .Enable(Enable), .Rx_done(Rx_done), .Rx_byte(Rx_byte),
        .Rx_en(Rx_en), .Pkt_valid(Pkt_valid), .Pkt_len(Pkt_len), .Pkt_addr(Pkt_addr),
        .Pkt_data(Pkt_data), .Pkt_rd(Pkt_rd), .Err_sig(Err_sig), .Err_cnt(Err_cnt)
    );

    always #10 CLK = ~CLK;

    initial begin
        #1_800_000;
        $display("FAIL watchdog: simulation exceeded 90000 cycles");
        $fatal(1);
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge CLK);
        Rx_done = 1'b1;
        Rx_byte = b;
        @(negedge CLK);
        Rx_done = 1'b0;
    endtask

    task automatic release_pkt();
        @(negedge CLK);
        Pkt_rd = 1'b1;
        @(negedge CLK);
        Pkt_rd = 1'b0;
    endtask

    task automatic test_reset();
        RSTn = 1'b0;
        Enable = 1'b1;
        repeat (3) @(negedge CLK);
        vectors++; if (Rx_en !== 1'b0) begin miscompares++; $display("FAIL reset_rx_en got %0b exp 0", Rx_en); end
        vectors++; if (Pkt_valid !== 1'b0) begin miscompares++; $display("FAIL reset_valid got %0b exp 0", Pkt_valid); end
        vectors++; if (Pkt_len !== 5'd0) begin miscompares++; $display("FAIL reset_len got %0d exp 0", Pkt_len); end
        vectors++; if (Pkt_data !== 8'd0) begin miscompares++; $display("FAIL reset_data got %h exp 00", Pkt_data); end
        vectors++; if (Err_sig !== 1'b0) begin miscompares++; $display("FAIL reset_err_sig got %0b exp 0", Err_sig); end
        vectors++; if (Err_cnt !== 8'd0) begin miscompares++; $display("FAIL reset_err_cnt got %0d exp 0", Err_cnt); end
        RSTn = 1'b1;
        @(negedge CLK);
        vectors++; if (Rx_en !== 1'b1) begin miscompares++; $display("FAIL idle_rx_en got %0b exp 1", Rx_en); end
    endtask

    task automatic test_good_packet();
        logic [7:0] exp_data [3];
        exp_data[0] = 8'h11; exp_data[1] = 8'h22; exp_data[2] = 8'h33;
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03);
        send_byte(8'h11); send_byte(8'h22); send_byte(8'h33); send_byte(8'h69);
        vectors++; if (Pkt_valid !== 1'b1) begin miscompares++; $display("FAIL good_valid got %0b exp 1", Pkt_valid); end
        vectors++; if (Pkt_len !== 5'd3) begin miscompares++; $display("FAIL good_len got %0d exp 3", Pkt_len); end
        vectors++; if (Rx_en !== 1'b0) begin miscompares++; $display("FAIL good_hold_rx_en got %0b exp 0", Rx_en); end
        for (int i = 0; i < 3; i++) begin
            Pkt_addr = 4'(i);
            @(negedge CLK);
            vectors++; if (Pkt_data !== exp_data[i]) begin miscompares++; $display("FAIL good_data[%0d] got %h exp %h", i, Pkt_data, exp_data[i]); end
        end
        send_byte(8'hAA);
        vectors++; if (Pkt_valid !== 1'b1) begin miscompares++; $display("FAIL hold_drop_valid got %0b exp 1", Pkt_valid); end
        release_pkt();
        vectors++; if (Pkt_valid !== 1'b0) begin miscompares++; $display("FAIL good_release_valid got %0b exp 0", Pkt_valid); end
        vectors++; if (Rx_en !== 1'b1) begin miscompares++; $display("FAIL good_release_rx_en got %0b exp 1", Rx_en); end
        vectors++; if (Err_cnt !== 8'd0) begin miscompares++; $display("FAIL good_err_cnt got %0d exp 0", Err_cnt); end
    endtask

    task automatic test_bad_sum();
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
        send_byte(8'h01); send_byte(8'h02);
        vectors++; if (Err_sig !== 1'b0) begin miscompares++; $display("FAIL badsum_pre_err got %0b exp 0", Err_sig); end
        send_byte(8'h00);
        vectors++; if (Err_sig !== 1'b1) begin miscompares++; $display("FAIL badsum_err_sig got %0b exp 1", Err_sig); end
        vectors++; if (Err_cnt !== 8'd1) begin miscompares++; $display("FAIL badsum_err_cnt got %0d exp 1", Err_cnt); end
        @(negedge CLK);
        vectors++; if (Err_sig !== 1'b0) begin miscompares++; $display("FAIL badsum_err_width got %0b exp 0", Err_sig); end
        vectors++; if (Pkt_valid !== 1'b0) begin miscompares++; $display("FAIL badsum_valid got %0b exp 0", Pkt_valid); end
    endtask

    task automatic test_lengths();
        send_byte(8'hAA); send_byte(8'hAA); send_byte(8'h55);
        send_byte(8'h01); send_byte(8'h7F); send_byte(8'h80);
        vectors++; if (Pkt_valid !== 1'b1) begin miscompares++; $display("FAIL rephdr_valid got %0b exp 1", Pkt_valid); end
        vectors++; if (Pkt_len !== 5'd1) begin miscompares++; $display("FAIL rephdr_len got %0d exp 1", Pkt_len); end
        Pkt_addr = 4'd0;
        @(negedge CLK);
        vectors++; if (Pkt_data !== 8'h7F) begin miscompares++; $display("FAIL rephdr_data got %h exp 7f", Pkt_data); end
        release_pkt();
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h00);
        vectors++; if (Err_sig !== 1'b1) begin miscompares++; $display("FAIL len0_err_sig got %0b exp 1", Err_sig); end
        vectors++; if (Err_cnt !== 8'd2) begin miscompares++; $display("FAIL len0_err_cnt got %0d exp 2", Err_cnt); end
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h11);
        vectors++; if (Err_sig !== 1'b1) begin miscompares++; $display("FAIL len17_err_sig got %0b exp 1", Err_sig); end
        vectors++; if (Err_cnt !== 8'd3) begin miscompares++; $display("FAIL len17_err_cnt got %0d exp 3", Err_cnt); end
        // Full 16-byte payload 01..10; sum = 0x10 + 0x88 = 0x98.
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h10);
        for (int i = 1; i <= 16; i++) send_byte(8'(i));
        send_byte(8'h98);
        vectors++; if (Pkt_valid !== 1'b1) begin miscompares++; $display("FAIL max_valid got %0b exp 1", Pkt_valid); end
        vectors++; if (Pkt_len !== 5'd16) begin miscompares++; $display("FAIL max_len got %0d exp 16", Pkt_len); end
        Pkt_addr = 4'd15;
        @(negedge CLK);
        vectors++; if (Pkt_data !== 8'h10) begin miscompares++; $display("FAIL max_data15 got %h exp 10", Pkt_data); end
        Pkt_addr = 4'd0;
        @(negedge CLK);
        vectors++; if (Pkt_data !== 8'h01) begin miscompares++; $display("FAIL max_data0 got %h exp 01", Pkt_data); end
        release_pkt();
        vectors++; if (Err_cnt !== 8'd3) begin miscompares++; $display("FAIL max_err_cnt got %0d exp 3", Err_cnt); end
    endtask

    task automatic test_timeout();
        int hit_at;
        hit_at = 0;
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h04); send_byte(8'h01);
        for (int i = 1; i <= 50010; i++) begin
            @(negedge CLK);
            if (Err_sig === 1'b1) begin
                hit_at = i;
                break;
            end
        end
        vectors++; if (hit_at != 50000) begin miscompares++; $display("FAIL timeout_cycle got %0d exp 50000", hit_at); end
        vectors++; if (Err_cnt !== 8'd4) begin miscompares++; $display("FAIL timeout_err_cnt got %0d exp 4", Err_cnt); end
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h01); send_byte(8'h05); send_byte(8'h06);
        vectors++; if (Pkt_valid !== 1'b1) begin miscompares++; $display("FAIL after_timeout_valid got %0b exp 1", Pkt_valid); end
        release_pkt();
    endtask

    task automatic test_enable_drop();
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h03); send_byte(8'h01);
        Enable = 1'b0;
        #1;
        vectors++; if (Rx_en !== 1'b0) begin miscompares++; $display("FAIL disable_rx_en got %0b exp 0", Rx_en); end
        repeat (2) @(negedge CLK);
        vectors++; if (Err_sig !== 1'b0) begin miscompares++; $display("FAIL disable_err_sig got %0b exp 0", Err_sig); end
        vectors++; if (Err_cnt !== 8'd4) begin miscompares++; $display("FAIL disable_err_cnt got %0d exp 4", Err_cnt); end
        Enable = 1'b1;
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h02);
        send_byte(8'h0A); send_byte(8'h0B); send_byte(8'h17);
        vectors++; if (Pkt_valid !== 1'b1) begin miscompares++; $display("FAIL reenable_valid got %0b exp 1", Pkt_valid); end
        Pkt_addr = 4'd1;
        @(negedge CLK);
        vectors++; if (Pkt_data !== 8'h0B) begin miscompares++; $display("FAIL reenable_data got %h exp 0b", Pkt_data); end
        release_pkt();
    endtask

    task automatic test_saturation_and_reset();
        for (int i = 0; i < 256; i++) begin
            send_byte(8'hAA);
            send_byte(8'h00);
        end
        vectors++; if (Err_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_err_cnt got %0d exp 255", Err_cnt); end
        send_byte(8'hAA); send_byte(8'h00);
        vectors++; if (Err_sig !== 1'b1) begin miscompares++; $display("FAIL sat_err_sig got %0b exp 1", Err_sig); end
        vectors++; if (Err_cnt !== 8'd255) begin miscompares++; $display("FAIL sat_hold got %0d exp 255", Err_cnt); end
        send_byte(8'hAA); send_byte(8'h55); send_byte(8'h05); send_byte(8'h01); send_byte(8'h02);
        RSTn = 1'b0;
        #1;
        vectors++; if (Rx_en !== 1'b0) begin miscompares++; $display("FAIL midrst_rx_en got %0b exp 0", Rx_en); end
        vectors++; if (Pkt_valid !== 1'b0) begin miscompares++; $display("FAIL midrst_valid got %0b exp 0", Pkt_valid); end
        vectors++; if (Pkt_len !== 5'd0) begin miscompares++; $display("FAIL midrst_len got %0d exp 0", Pkt_len); end
        vectors++; if (Pkt_data !== 8'd0) begin miscompares++; $display("FAIL midrst_data got %h exp 00", Pkt_data); end
        vectors++; if (Err_sig !== 1'b0) begin miscompares++; $display("FAIL midrst_err_sig got %0b exp 0", Err_sig); end
        vectors++; if (Err_cnt !== 8'd0) begin miscompares++; $display("FAIL midrst_err_cnt got %0d exp 0", Err_cnt); end
        @(negedge CLK);
        RSTn = 1'b1;
        send_byte(8'h03); send_byte(8'h04);
        vectors++; if (Err_cnt !== 8'd0) begin miscompares++; $display("FAIL postrst_err_cnt got %0d exp 0", Err_cnt); end
        vectors++; if (Pkt_valid !== 1'b0) begin miscompares++; $display("FAIL postrst_valid got %0b exp 0", Pkt_valid); end
    endtask

    initial begin
        test_reset();
        test_good_packet();
        test_bad_sum();
        test_lengths();
        test_timeout();
        test_enable_drop();
        test_saturation_and_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
